// File: rtl/npu_pkg.sv
// Shared constants for the NPU requantization datapath.
//   ACC_W_DEF / DATA_W_DEF : default accumulator and activation widths
//   SAT_MAX_DEF/SAT_MIN_DEF: clamp bounds for the default activation width
//   sat_max()/sat_min()    : clamp bounds for an arbitrary signed width
package npu_pkg;

   localparam int unsigned ACC_W_DEF  = 32;
   localparam int unsigned DATA_W_DEF = 8;

   localparam int SAT_MAX_DEF = 127;
   localparam int SAT_MIN_DEF = -128;

   function automatic int sat_max(input int unsigned w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int unsigned w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/requant_clamp.sv
// Combinational round / zero-point / clamp stage of the requantizer.
//   product : signed scaled accumulator (ACC_W+SCALE_W+1 bits)
//   shift   : rounding right-shift amount
//   zp      : signed output zero point
//   relu    : raise the lower clamp bound to zp
//   data    : clamped signed result
//   sat     : result was outside the representable DATA_W range
module requant_clamp
   import npu_pkg::*;
#(
   parameter int unsigned ACC_W   = ACC_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned SCALE_W = 16,
   parameter int unsigned SHIFT_W = 5
) (
   input  logic signed [ACC_W+SCALE_W:0] product,
   input  logic        [SHIFT_W-1:0]     shift,
   input  logic signed [DATA_W-1:0]      zp,
   input  logic                          relu,
   output logic signed [DATA_W-1:0]      data,
   output logic                          sat
);

   localparam int unsigned PROD_W = ACC_W + SCALE_W + 1;
   // One guard bit for the rounding add, one more for the zero-point add.
   localparam int unsigned RND_W  = PROD_W + 1;
   localparam int unsigned SUM_W  = RND_W + 1;

   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(DATA_W));
   localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(DATA_W));

   logic signed [RND_W-1:0] prod_ext;
   logic        [RND_W-1:0] rnd;
   logic signed [RND_W-1:0] rounded;
   logic signed [RND_W-1:0] r;
   logic signed [SUM_W-1:0] zp_ext;
   logic signed [SUM_W-1:0] v;
   logic signed [SUM_W-1:0] lo;

   always_comb begin
      prod_ext = {product[PROD_W-1], product};
      rnd      = '0;
      if (shift != '0) begin
         rnd = RND_W'(1) << (shift - SHIFT_W'(1));
      end
      rounded = prod_ext + $signed(rnd);
      // Arithmetic shift floors, so adding half first gives round-half-up.
      r       = rounded >>> shift;
      zp_ext  = {{(SUM_W - DATA_W){zp[DATA_W-1]}}, zp};
      v       = {r[RND_W-1], r} + zp_ext;
      // zp is always >= MIN_V, so max(MIN_V, zp) reduces to zp.
      lo      = relu ? zp_ext : MIN_V;
      // Only range overflow counts as saturation, never the relu floor.
      sat     = (v > MAX_V) || (v < MIN_V);
      if (v > MAX_V) begin
         data = MAX_V[DATA_W-1:0];
      end else if (v < lo) begin
         data = lo[DATA_W-1:0];
      end else begin
         data = v[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/requant_int8.sv
// Two-stage int32 -> int8 requantizer with valid/ready handshakes.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : input handshake; in_acc is the signed accumulator
//   cfg_scale/shift/zp/relu : per-element config, sampled at input acceptance
//   out_valid/out_ready: output handshake; out_data result, out_sat clamp flag
//   clr_stats, sat_cnt : synchronous clear and saturating count of clamped outputs
module requant_int8
   import npu_pkg::*;
#(
   parameter int unsigned ACC_W   = ACC_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned SCALE_W = 16,
   parameter int unsigned SHIFT_W = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [ACC_W-1:0]   in_acc,
   input  logic        [SCALE_W-1:0] cfg_scale,
   input  logic        [SHIFT_W-1:0] cfg_shift,
   input  logic signed [DATA_W-1:0]  cfg_zp,
   input  logic                      cfg_relu,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [DATA_W-1:0]  out_data,
   output logic                      out_sat,
   input  logic                      clr_stats,
   output logic        [CNT_W-1:0]   sat_cnt
);

   localparam int unsigned PROD_W = ACC_W + SCALE_W + 1;

   logic                     adv;
   logic signed [PROD_W-1:0] acc_ext;
   logic signed [PROD_W-1:0] scale_ext;
   logic signed [PROD_W-1:0] product_d;

   logic                     s1_valid_q;
   logic signed [PROD_W-1:0] s1_prod_q;
   logic        [SHIFT_W-1:0] s1_shift_q;
   logic signed [DATA_W-1:0] s1_zp_q;
   logic                     s1_relu_q;

   logic                     out_valid_q;
   logic signed [DATA_W-1:0] out_data_q;
   logic                     out_sat_q;
   logic        [CNT_W-1:0]  sat_cnt_q;

   logic signed [DATA_W-1:0] clamp_data;
   logic                     clamp_sat;
   logic                     cnt_hit;

   // Whole pipeline moves in lockstep; a stalled output freezes both stages.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // Scale is unsigned: zero-extend it so the signed multiply stays exact.
   always_comb begin
      acc_ext   = {{(SCALE_W + 1){in_acc[ACC_W-1]}}, in_acc};
      scale_ext = {{(ACC_W + 1){1'b0}}, cfg_scale};
      product_d = acc_ext * scale_ext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_shift_q <= '0;
         s1_zp_q    <= '0;
         s1_relu_q  <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_prod_q  <= product_d;
            s1_shift_q <= cfg_shift;
            s1_zp_q    <= cfg_zp;
            s1_relu_q  <= cfg_relu;
         end
      end
   end

   requant_clamp #(
      .ACC_W   (ACC_W),
      .DATA_W  (DATA_W),
      .SCALE_W (SCALE_W),
      .SHIFT_W (SHIFT_W)
   ) u_clamp (
      .product (s1_prod_q),
      .shift   (s1_shift_q),
      .zp      (s1_zp_q),
      .relu    (s1_relu_q),
      .data    (clamp_data),
      .sat     (clamp_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_q <= clamp_data;
            out_sat_q  <= clamp_sat;
         end
      end
   end

   assign cnt_hit = out_valid_q && out_ready && out_sat_q;

   // Clear wins over a coincident counted handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt_q <= '0;
      end else if (clr_stats) begin
         sat_cnt_q <= '0;
      end else if (cnt_hit && (sat_cnt_q != '1)) begin
         sat_cnt_q <= sat_cnt_q + CNT_W'(1);
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_requant_int8.sv
// Self-checking bench for requant_int8: directed spec examples plus randomized
// streams with backpressure, checked against an arithmetic reference model.
module tb_requant_int8;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_acc;
   logic        [15:0] cfg_scale;
   logic        [4:0]  cfg_shift;
   logic signed [7:0]  cfg_zp;
   logic               cfg_relu;
   logic               out_valid;
   logic               out_ready;
   logic signed [7:0]  out_data;
   logic               out_sat;
   logic               clr_stats;
   logic [CNT_W-1:0]   sat_cnt;

   logic bp_en;
   logic bp_rdy;
   logic man_rdy;

   int checks;
   int errors;

   logic [7:0] exp_data[$];
   logic       exp_sat[$];
   logic [7:0] got_data[$];
   logic       got_sat[$];
   int         got_base;

   assign out_ready = bp_en ? bp_rdy : man_rdy;

   requant_int8 #(
      .ACC_W   (32),
      .DATA_W  (8),
      .SCALE_W (16),
      .SHIFT_W (5),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .cfg_scale (cfg_scale),
      .cfg_shift (cfg_shift),
      .cfg_zp    (cfg_zp),
      .cfg_relu  (cfg_relu),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .clr_stats (clr_stats),
      .sat_cnt   (sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bp_en) begin
         #1;
         bp_rdy = ($urandom_range(0, 2) != 0);
      end
   end

   // Records every output handshake; inputs only change just after posedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_sat.push_back(out_sat);
      end
   end

   // Reference: floor((acc*scale + half) / 2^shift) + zp, then range/relu clamp.
   function automatic void ref_model(input logic signed [31:0] acc, input logic [15:0] scale,
                                     input logic [4:0] shift, input logic signed [7:0] zp,
                                     input logic relu, output logic [7:0] d, output logic s);
      longint p, den, num, q, v, lo;
      p   = longint'(acc) * longint'(scale);
      den = longint'(1) << shift;
      num = p + den / 2;
      q   = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
      v  = q + longint'(zp);
      s  = (v > 127) || (v < -128);
      lo = relu ? longint'(zp) : -128;
      if (v > 127) d = 8'h7F;
      else if (v < lo) d = lo[7:0];
      else d = v[7:0];
   endfunction

   task automatic start_test();
      exp_data.delete();
      exp_sat.delete();
      got_base = got_data.size();
   endtask

   task automatic drive_elem(input logic signed [31:0] acc, input logic [15:0] scale,
                             input logic [4:0] shift, input logic signed [7:0] zp,
                             input logic relu);
      int         n;
      logic [7:0] ed;
      logic       es;
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_acc    = acc;
      cfg_scale = scale;
      cfg_shift = shift;
      cfg_zp    = zp;
      cfg_relu  = relu;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout in_ready=%b want 1", in_ready);
      end else begin
         ref_model(acc, scale, shift, zp, relu, ed, es);
         exp_data.push_back(ed);
         exp_sat.push_back(es);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #1;
      clr_stats = 1'b1;
      @(posedge clk);
      #1;
      clr_stats = 1'b0;
   endtask

   task automatic wait_drain(output bit ok);
      bp_en = 1'b0;
      @(posedge clk);
      #1;
      man_rdy = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if ((got_data.size() - got_base) >= exp_data.size() && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic rand_elem();
      logic signed [31:0] a;
      logic [4:0]         sh;
      if ($urandom_range(0, 1) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 200000)) - 32'sd100000;
      if ($urandom_range(0, 3) == 0) sh = 5'($urandom_range(0, 31));
      else sh = 5'($urandom_range(10, 31));
      drive_elem(a, 16'($urandom_range(0, 65535)), sh, 8'($urandom), 1'($urandom));
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sat !== 1'b0 || sat_cnt !== '0) begin
         errors++;
         $display("FAIL reset_outputs valid=%b data=%h sat=%b cnt=%0d want 0 0 0 0",
                  out_valid, out_data, out_sat, sat_cnt);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset ready=%b valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_acc = 32'sd1000; cfg_scale = 16'd1;
      cfg_shift = 5'd3; cfg_zp = 8'sd0; cfg_relu = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early out_valid=%b want 0", out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'sd125 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL basic_125 valid=%b data=%0d sat=%b want 1 125 0",
                  out_valid, out_data, out_sat);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bubble_drain out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_round();
      bit ok;
      start_test();
      drive_elem(-32'sd12, 16'd1, 5'd3, 8'sd0, 1'b0);
      drive_elem(-32'sd13, 16'd1, 5'd3, 8'sd0, 1'b0);
      idle();
      wait_drain(ok);
      checks++;
      if (!ok || got_data.size() - got_base != 2) begin
         errors++;
         $display("FAIL round_count got %0d want 2", got_data.size() - got_base);
      end else begin
         checks++;
         if (got_data[got_base] !== 8'hFF || got_data[got_base+1] !== 8'hFE) begin
            errors++;
            $display("FAIL round_half_up got %0d %0d want -1 -2",
                     $signed(got_data[got_base]), $signed(got_data[got_base+1]));
         end
      end
   endtask

   task automatic test_sat();
      bit ok;
      int n;
      pulse_clr();
      start_test();
      drive_elem(32'sh7FFFFFFF, 16'hFFFF, 5'd0, 8'sd0, 1'b0);
      drive_elem(32'sh80000000, 16'hFFFF, 5'd0, 8'sd0, 1'b0);
      idle();
      wait_drain(ok);
      checks++;
      if (!ok || got_data.size() - got_base != 2) begin
         errors++;
         $display("FAIL sat_count_out got %0d want 2", got_data.size() - got_base);
      end else begin
         checks++;
         if (got_data[got_base] !== 8'h7F || got_sat[got_base] !== 1'b1 ||
             got_data[got_base+1] !== 8'h80 || got_sat[got_base+1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_values got %h/%b %h/%b want 7f/1 80/1", got_data[got_base],
                     got_sat[got_base], got_data[got_base+1], got_sat[got_base+1]);
         end
      end
      checks++;
      if (sat_cnt !== 4'd2) begin
         errors++;
         $display("FAIL sat_cnt got %0d want 2", sat_cnt);
      end
      // Park a saturating element at the output, then clear on its handshake.
      man_rdy = 1'b0;
      drive_elem(32'sh7FFFFFFF, 16'hFFFF, 5'd0, 8'sd0, 1'b0);
      idle();
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      clr_stats = 1'b1;
      man_rdy   = 1'b1;
      @(posedge clk);
      #1;
      clr_stats = 1'b0;
      checks++;
      if (n >= 10 || sat_cnt !== 4'd0) begin
         errors++;
         $display("FAIL clr_vs_count sat_cnt=%0d want 0", sat_cnt);
      end
   endtask

   task automatic test_relu();
      bit ok;
      start_test();
      drive_elem(-32'sd100, 16'd1, 5'd0, 8'sd10, 1'b1);
      idle();
      wait_drain(ok);
      checks++;
      if (!ok || got_data.size() - got_base != 1) begin
         errors++;
         $display("FAIL relu_count got %0d want 1", got_data.size() - got_base);
      end else begin
         checks++;
         if (got_data[got_base] !== 8'd10 || got_sat[got_base] !== 1'b0) begin
            errors++;
            $display("FAIL relu_floor got %0d/%b want 10/0",
                     $signed(got_data[got_base]), got_sat[got_base]);
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      start_test();
      man_rdy = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) rand_elem();
            idle();
         end
         begin
            int n;
            n = 0;
            while ((got_data.size() - got_base) < 2 && n < 200) begin
               @(negedge clk);
               n++;
            end
            @(posedge clk);
            #1;
            man_rdy = 1'b0;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               checks++;
               if (n >= 200 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL stall_hold cyc %0d in_ready=%b out_valid=%b want 0 1",
                           c, in_ready, out_valid);
               end
            end
            @(posedge clk);
            #1;
            man_rdy = 1'b1;
         end
      join
      wait_drain(ok);
      checks++;
      if (!ok || got_data.size() - got_base != exp_data.size()) begin
         errors++;
         $display("FAIL stall_count got %0d want %0d", got_data.size() - got_base, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && got_base + i < got_data.size(); i++) begin
         checks++;
         if (got_data[got_base+i] !== exp_data[i] || got_sat[got_base+i] !== exp_sat[i]) begin
            errors++;
            $display("FAIL stall_elem %0d got %h/%b want %h/%b", i, got_data[got_base+i],
                     got_sat[got_base+i], exp_data[i], exp_sat[i]);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      int nsat;
      pulse_clr();
      start_test();
      bp_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rand_elem();
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      wait_drain(ok);
      checks++;
      if (!ok || got_data.size() - got_base != exp_data.size()) begin
         errors++;
         $display("FAIL rand_count got %0d want %0d", got_data.size() - got_base, exp_data.size());
      end
      nsat = 0;
      for (int i = 0; i < exp_data.size() && got_base + i < got_data.size(); i++) begin
         checks++;
         if (exp_sat[i]) nsat++;
         if (got_data[got_base+i] !== exp_data[i] || got_sat[got_base+i] !== exp_sat[i]) begin
            errors++;
            $display("FAIL rand_elem %0d got %h/%b want %h/%b", i, got_data[got_base+i],
                     got_sat[got_base+i], exp_data[i], exp_sat[i]);
         end
      end
      if (nsat > CNT_MAX) nsat = CNT_MAX;
      checks++;
      if (sat_cnt !== CNT_W'(nsat)) begin
         errors++;
         $display("FAIL rand_sat_cnt got %0d want %0d", sat_cnt, nsat);
      end
   endtask

   task automatic test_cnt_saturate();
      bit ok;
      pulse_clr();
      start_test();
      for (int i = 0; i < 20; i++) drive_elem(32'sh7FFFFFFF, 16'hFFFF, 5'd0, 8'sd0, 1'b0);
      idle();
      wait_drain(ok);
      checks++;
      if (!ok || sat_cnt !== CNT_W'(CNT_MAX)) begin
         errors++;
         $display("FAIL cnt_saturate got %0d want %0d", sat_cnt, CNT_MAX);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      start_test();
      drive_elem(32'sh7FFFFFFF, 16'hFFFF, 5'd0, 8'sd0, 1'b0);
      idle();
      wait_drain(ok);
      man_rdy = 1'b0;
      drive_elem(32'sd500, 16'd3, 5'd2, 8'sd1, 1'b0);
      drive_elem(-32'sd500, 16'd3, 5'd2, 8'sd1, 1'b0);
      idle();
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sat_cnt !== '0 || out_data !== 8'h00 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid valid=%b cnt=%0d data=%h sat=%b want 0 0 0 0",
                  out_valid, sat_cnt, out_data, out_sat);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_ready got %b want 1", in_ready);
      end
      start_test();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      man_rdy = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (got_data.size() != got_base || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_stale got %0d outputs valid=%b want 0 0",
                  got_data.size() - got_base, out_valid);
      end
   endtask

   initial begin
      checks = 0; errors = 0; got_base = 0;
      rst = 1'b1; in_valid = 1'b0; in_acc = '0; cfg_scale = '0; cfg_shift = '0;
      cfg_zp = '0; cfg_relu = 1'b0; clr_stats = 1'b0;
      bp_en = 1'b0; bp_rdy = 1'b1; man_rdy = 1'b1;
      test_reset();
      test_basic();
      test_round();
      test_sat();
      test_relu();
      test_stall();
      test_random();
      test_cnt_saturate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
